video_in_frame_scheduler: RTL and testbench

Frame-buffer scheduler placed between the video-in DMA writer and the HPS frame consumer in the video-in subsystem. It owns a pool of NUM_BUF frame buffers in FPGA SDRAM and tracks each one as FREE, WRITING, READY or READING. It grants the writer a buffer at each frame start and hands the reader the newest completed frame. Stale frames are dropped so the consumer never blocks capture.

---
 rtl/video_in_frame_scheduler.sv | 171 +++++++++++++++++
 tb/tb_video_in_frame_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_in_frame_scheduler.sv
// rtl/video_in_frame_scheduler.sv - frame-buffer pool scheduler between video-in DMA writer and HPS reader; VIDEO_IN_FRAME_DROP_CNT_EN adds drop_cnt/drop_clr
module video_in_frame_scheduler #(
  parameter int          NUM_BUF      = 3,
  parameter logic [31:0] BASE_ADDR    = 32'hC000_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0004_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  output logic        wr_grant,
  output logic [31:0] wr_addr,
  input  logic        wr_done,
  input  logic        wr_abort,
  input  logic        rd_req,
  output logic        rd_grant,
  output logic [31:0] rd_addr,
  output logic [15:0] rd_seq,
  input  logic        rd_release,
  output logic        overflow,
  input  logic        ovf_clr
`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt,
  input  logic        drop_clr
`endif
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } buf_state_t;

  // Storage is sized for the largest legal pool; entries at or above NUM_BUF stay FREE and are never scanned.
  buf_state_t  st  [4];
  logic [15:0] seq [4];
  logic [15:0] fcnt;

  logic       w_any, r_any, y_any, f_any;
  logic [1:0] w_idx, r_idx, y_idx, f_idx;
  logic       rd_take, wr_take, do_done, do_abort, do_rel, starve;
  logic [1:0] g_idx;

  function automatic logic [31:0] buf_addr(input logic [1:0] idx);
    buf_addr = BASE_ADDR + FRAME_STRIDE * {30'd0, idx};
  endfunction

  // Locate the WRITING, READING and READY buffers and the lowest-index FREE one.
  always_comb begin
    w_any = 1'b0;
    r_any = 1'b0;
    y_any = 1'b0;
    f_any = 1'b0;
    w_idx = 2'd0;
    r_idx = 2'd0;
    y_idx = 2'd0;
    f_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i < NUM_BUF) begin
        if (st[i] == FREE) begin
          f_any = 1'b1;
          f_idx = 2'(i);
        end
        if (st[i] == WRITING) begin
          w_any = 1'b1;
          w_idx = 2'(i);
        end
        if (st[i] == READY) begin
          y_any = 1'b1;
          y_idx = 2'(i);
        end
        if (st[i] == READING) begin
          r_any = 1'b1;
          r_idx = 2'(i);
        end
      end
    end
  end

  // Grant and event decisions from the state registered at the start of the cycle.
  always_comb begin
    rd_take  = rd_req && !r_any && y_any;
    // The reader wins a contested READY buffer; the writer recycles READY only when nothing is FREE.
    wr_take  = wr_req && !w_any && (f_any || (y_any && !rd_take));
    g_idx    = f_any ? f_idx : y_idx;
    do_abort = wr_abort && w_any;
    do_done  = wr_done && !wr_abort && w_any;
    do_rel   = rd_release && r_any;
    // A pending request that finds no FREE and no READY buffer marks the writer as starved,
    // even while it still holds its current buffer.
    starve   = wr_req && !f_any && !y_any;
  end

  // Buffer ownership, sequence numbers, grants and registered addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        st[i]  <= FREE;
        seq[i] <= 16'd0;
      end
      fcnt     <= 16'd0;
      wr_grant <= 1'b0;
      rd_grant <= 1'b0;
      wr_addr  <= 32'd0;
      rd_addr  <= 32'd0;
      rd_seq   <= 16'd0;
      overflow <= 1'b0;
    end else begin
      wr_grant <= wr_take;
      rd_grant <= rd_take;
      if (wr_take) begin
        wr_addr <= buf_addr(g_idx);
      end
      if (rd_take) begin
        rd_addr <= buf_addr(y_idx);
        rd_seq  <= seq[y_idx];
      end
      if (starve) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (do_abort) begin
        st[w_idx] <= FREE;
      end else if (do_done) begin
        st[w_idx]  <= READY;
        seq[w_idx] <= fcnt;
        fcnt       <= fcnt + 16'd1;
        // The older READY frame is dropped unless the reader claims it this same cycle.
        if (y_any && !rd_take) begin
          st[y_idx] <= FREE;
        end
      end
      if (rd_take) begin
        st[y_idx] <= READING;
      end
      if (do_rel) begin
        st[r_idx] <= FREE;
      end
      if (wr_take) begin
        st[g_idx] <= WRITING;
      end
    end
  end

`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
  logic drop_evt;

  // A frame is lost when a completed frame supersedes an unread one or the writer recycles it.
  always_comb begin
    drop_evt = (wr_take && !f_any) || (do_done && y_any && !rd_take);
  end

  // Saturating drop counter; a same-cycle drop beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= 16'd0;
    end else if (drop_evt) begin
      if (drop_clr) begin
        drop_cnt <= 16'd1;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (drop_clr) begin
      drop_cnt <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_video_in_frame_scheduler.sv
// tb/tb_video_in_frame_scheduler.sv - self-checking bench for video_in_frame_scheduler (pools of 3 and 2 buffers)
module tb_video_in_frame_scheduler;

  localparam logic [31:0] BASE   = 32'hC000_0000;
  localparam logic [31:0] STRIDE = 32'h0004_0000;
  localparam int S_FREE = 0, S_WRITING = 1, S_READY = 2, S_READING = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2], wr_req [2], wr_done [2], wr_abort [2];
  logic        rd_req [2], rd_release [2], ovf_clr [2];
  logic        wr_grant [2], rd_grant [2], overflow [2];
  logic [31:0] wr_addr [2], rd_addr [2];
  logic [15:0] rd_seq [2];
`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
  logic        drop_clr [2];
  logic [15:0] drop_cnt [2];
`endif

  video_in_frame_scheduler #(.NUM_BUF(3)) u_dut3 (
    .clk(clk), .reset(reset[0]), .wr_req(wr_req[0]), .wr_grant(wr_grant[0]), .wr_addr(wr_addr[0]),
    .wr_done(wr_done[0]), .wr_abort(wr_abort[0]), .rd_req(rd_req[0]), .rd_grant(rd_grant[0]),
    .rd_addr(rd_addr[0]), .rd_seq(rd_seq[0]), .rd_release(rd_release[0]), .overflow(overflow[0]),
    .ovf_clr(ovf_clr[0])
`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
    , .drop_cnt(drop_cnt[0]), .drop_clr(drop_clr[0])
`endif
  );

  video_in_frame_scheduler #(.NUM_BUF(2)) u_dut2 (
    .clk(clk), .reset(reset[1]), .wr_req(wr_req[1]), .wr_grant(wr_grant[1]), .wr_addr(wr_addr[1]),
    .wr_done(wr_done[1]), .wr_abort(wr_abort[1]), .rd_req(rd_req[1]), .rd_grant(rd_grant[1]),
    .rd_addr(rd_addr[1]), .rd_seq(rd_seq[1]), .rd_release(rd_release[1]), .overflow(overflow[1]),
    .ovf_clr(ovf_clr[1])
`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
    , .drop_cnt(drop_cnt[1]), .drop_clr(drop_clr[1])
`endif
  );

  // Reference model: ownership table per pool, expected registered outputs.
  int          nb [2] = '{3, 2};
  int          mst [2][4];
  int          mseq [2][4];
  int          mfcnt [2];
  int          mdrops [2];
  logic        e_wg [2], e_rg [2], e_ovf [2];
  logic [31:0] e_wa [2], e_ra [2];
  logic [15:0] e_rs [2];
  int          errors = 0;
  int          checks = 0;

  function automatic int find(input int k, input int s);
    for (int i = 0; i < nb[k]; i++) if (mst[k][i] == s) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    int wb, rb, yb, fb, gi;
    bit rd_go, drop;
    int nxt [4];
    if (reset[k]) begin
      for (int i = 0; i < 4; i++) begin
        mst[k][i] = S_FREE;
        mseq[k][i] = 0;
      end
      mfcnt[k] = 0; mdrops[k] = 0;
      e_wg[k] = 0; e_rg[k] = 0; e_ovf[k] = 0;
      e_wa[k] = 0; e_ra[k] = 0; e_rs[k] = 0;
      return;
    end
    wb = find(k, S_WRITING); rb = find(k, S_READING);
    yb = find(k, S_READY);   fb = find(k, S_FREE);
    rd_go = rd_req[k] && rb < 0 && yb >= 0;
    gi = -1;
    if (wr_req[k] && wb < 0) begin
      if (fb >= 0) gi = fb;
      else if (yb >= 0 && !rd_go) gi = yb;
    end
    drop = (gi >= 0 && fb < 0);
    e_wg[k] = (gi >= 0);
    e_rg[k] = rd_go;
    if (gi >= 0) e_wa[k] = BASE + STRIDE * 32'(gi);
    if (rd_go) begin
      e_ra[k] = BASE + STRIDE * 32'(yb);
      e_rs[k] = 16'(mseq[k][yb]);
    end
    if (wr_req[k] && fb < 0 && yb < 0) e_ovf[k] = 1'b1;
    else if (ovf_clr[k]) e_ovf[k] = 1'b0;
    for (int i = 0; i < 4; i++) nxt[i] = mst[k][i];
    if (wb >= 0 && wr_abort[k]) nxt[wb] = S_FREE;
    else if (wb >= 0 && wr_done[k]) begin
      nxt[wb] = S_READY;
      mseq[k][wb] = mfcnt[k];
      mfcnt[k] = (mfcnt[k] + 1) % 65536;
      if (yb >= 0 && !rd_go) begin
        nxt[yb] = S_FREE;
        drop = 1;
      end
    end
    if (rd_go) nxt[yb] = S_READING;
    if (rb >= 0 && rd_release[k]) nxt[rb] = S_FREE;
    if (gi >= 0) nxt[gi] = S_WRITING;
    for (int i = 0; i < 4; i++) mst[k][i] = nxt[i];
`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
    if (drop) mdrops[k] = drop_clr[k] ? 1 : (mdrops[k] < 65535 ? mdrops[k] + 1 : 65535);
    else if (drop_clr[k]) mdrops[k] = 0;
`else
    if (drop && mdrops[k] < 65535) mdrops[k]++;
`endif
  endtask

  // Advance one clock: update the model with the current inputs, then compare every output.
  task automatic cycle();
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wr_grant[%0d]", k), 32'(wr_grant[k]), 32'(e_wg[k]));
      chk($sformatf("wr_addr[%0d]", k), wr_addr[k], e_wa[k]);
      chk($sformatf("rd_grant[%0d]", k), 32'(rd_grant[k]), 32'(e_rg[k]));
      chk($sformatf("rd_addr[%0d]", k), rd_addr[k], e_ra[k]);
      chk($sformatf("rd_seq[%0d]", k), 32'(rd_seq[k]), 32'(e_rs[k]));
      chk($sformatf("overflow[%0d]", k), 32'(overflow[k]), 32'(e_ovf[k]));
`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
      chk($sformatf("drop_cnt[%0d]", k), 32'(drop_cnt[k]), 32'(mdrops[k]));
`endif
    end
  endtask

  task automatic do_reset(input int k);
    reset[k] = 1'b1;
    cycle();
    reset[k] = 1'b0;
  endtask

  task automatic write_frame(input int k);
    wr_req[k] = 1'b1;
    cycle();
    wr_req[k] = 1'b0;
    wr_done[k] = 1'b1;
    cycle();
    wr_done[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; wr_req[k] = 0; wr_done[k] = 0; wr_abort[k] = 0;
      rd_req[k] = 0; rd_release[k] = 0; ovf_clr[k] = 0;
`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
      drop_clr[k] = 0;
`endif
    end
    cycle();
    cycle();
    chk("reset wr_addr", wr_addr[0], 32'd0);
    chk("reset rd_addr", rd_addr[0], 32'd0);
    chk("reset rd_seq", 32'(rd_seq[0]), 32'd0);
    chk("reset overflow", 32'(overflow[0]), 32'd0);
    reset[0] = 1'b0;

    // Basic capture.
    wr_req[0] = 1; cycle();
    chk("basic wr_grant", 32'(wr_grant[0]), 32'd1);
    chk("basic wr_addr", wr_addr[0], 32'hC000_0000);
    wr_req[0] = 0; wr_done[0] = 1; cycle(); wr_done[0] = 0;
    rd_req[0] = 1; cycle(); rd_req[0] = 0;
    chk("basic rd_grant", 32'(rd_grant[0]), 32'd1);
    chk("basic rd_addr", rd_addr[0], 32'hC000_0000);
    chk("basic rd_seq", 32'(rd_seq[0]), 32'd0);
    rd_release[0] = 1; cycle(); rd_release[0] = 0;

    // Drop-newest with an idle reader.
    do_reset(0);
    repeat (3) write_frame(0);
    rd_req[0] = 1; cycle(); rd_req[0] = 0;
    chk("dropnew rd_seq", 32'(rd_seq[0]), 32'd2);
    chk("dropnew rd_addr", rd_addr[0], 32'hC000_0000);
    chk("dropnew model drops", 32'(mdrops[0]), 32'd2);
`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
    chk("dropnew drop_cnt", 32'(drop_cnt[0]), 32'd2);
`endif

    // wr_done and rd_req in the same cycle with buffer 0 READY.
    do_reset(0);
    write_frame(0);
    wr_req[0] = 1; cycle(); wr_req[0] = 0;
    chk("simul wr_addr", wr_addr[0], 32'hC004_0000);
    wr_done[0] = 1; rd_req[0] = 1; cycle(); wr_done[0] = 0; rd_req[0] = 0;
    chk("simul rd_grant", 32'(rd_grant[0]), 32'd1);
    chk("simul rd_addr", rd_addr[0], 32'hC000_0000);
    rd_release[0] = 1; cycle(); rd_release[0] = 0;
    rd_req[0] = 1; cycle(); rd_req[0] = 0;
    chk("simul next rd_addr", rd_addr[0], 32'hC004_0000);
    chk("simul next rd_seq", 32'(rd_seq[0]), 32'd1);

    // wr_done with wr_abort: abort wins, frame counter holds.
    wr_req[0] = 1; cycle(); wr_req[0] = 0;
    wr_done[0] = 1; wr_abort[0] = 1; cycle(); wr_done[0] = 0; wr_abort[0] = 0;
    wr_req[0] = 1; cycle(); wr_req[0] = 0;
    chk("abort regrant", wr_addr[0], 32'hC000_0000);
    wr_done[0] = 1; cycle(); wr_done[0] = 0;
    rd_release[0] = 1; cycle(); rd_release[0] = 0;
    rd_req[0] = 1; cycle(); rd_req[0] = 0;
    chk("abort rd_seq", 32'(rd_seq[0]), 32'd2);

    // Reset while both sides hold buffers.
    wr_req[0] = 1; cycle(); wr_req[0] = 0;
    reset[0] = 1; cycle(); reset[0] = 0;
    chk("midrst wr_addr", wr_addr[0], 32'd0);
    chk("midrst rd_addr", rd_addr[0], 32'd0);
    chk("midrst rd_seq", 32'(rd_seq[0]), 32'd0);
    chk("midrst rd_grant", 32'(rd_grant[0]), 32'd0);
    wr_req[0] = 1; cycle(); wr_req[0] = 0;
    chk("midrst regrant", wr_addr[0], 32'hC000_0000);

    // Protocol violations while idle.
    do_reset(0);
    rd_release[0] = 1; wr_done[0] = 1; cycle(); rd_release[0] = 0; wr_done[0] = 0;
    chk("viol wr_grant", 32'(wr_grant[0]), 32'd0);
    chk("viol wr_addr", wr_addr[0], 32'd0);
    write_frame(0);
    rd_req[0] = 1; cycle(); rd_req[0] = 0;
    chk("viol rd_seq", 32'(rd_seq[0]), 32'd0);

    // Starvation on the two-buffer pool.
    reset[0] = 1;
    do_reset(1);
    write_frame(1);
    rd_req[1] = 1; cycle(); rd_req[1] = 0;
    wr_req[1] = 1; cycle(); wr_req[1] = 0;
    chk("starve wr_addr", wr_addr[1], 32'hC004_0000);
    wr_done[1] = 1; cycle(); wr_done[1] = 0;
    wr_req[1] = 1; cycle(); wr_req[1] = 0;
    chk("recycle wr_grant", 32'(wr_grant[1]), 32'd1);
    chk("recycle wr_addr", wr_addr[1], 32'hC004_0000);
    chk("recycle overflow", 32'(overflow[1]), 32'd0);
    wr_req[1] = 1; cycle();
    chk("starve overflow", 32'(overflow[1]), 32'd1);
    chk("starve no grant", 32'(wr_grant[1]), 32'd0);
    ovf_clr[1] = 1; cycle(); ovf_clr[1] = 0;
    chk("ovf set beats clr", 32'(overflow[1]), 32'd1);
    rd_release[1] = 1; wr_done[1] = 1; cycle(); rd_release[1] = 0; wr_done[1] = 0;
    chk("release +1 no grant", 32'(wr_grant[1]), 32'd0);
    cycle(); wr_req[1] = 0;
    chk("release +2 grant", 32'(wr_grant[1]), 32'd1);
    chk("release +2 wr_addr", wr_addr[1], 32'hC000_0000);
    ovf_clr[1] = 1; cycle(); ovf_clr[1] = 0;
    chk("ovf cleared", 32'(overflow[1]), 32'd0);

    // Randomized protocol-following traffic on both pools.
    reset[0] = 1; reset[1] = 1; cycle();
    reset[0] = 0; reset[1] = 0;
    wr_req[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        bit w_hold, r_hold;
        w_hold = find(k, S_WRITING) >= 0;
        r_hold = find(k, S_READING) >= 0;
        reset[k] = ($urandom % 400) == 0;
        if (e_wg[k]) wr_req[k] = 0;
        else if (!wr_req[k] && ($urandom % 4) == 0 && (!w_hold || ($urandom % 4) == 0)) wr_req[k] = 1;
        wr_done[k]  = (w_hold && ($urandom % 5) == 0) || ($urandom % 40) == 0;
        wr_abort[k] = (w_hold && ($urandom % 14) == 0) || ($urandom % 60) == 0;
        if (e_rg[k]) rd_req[k] = 0;
        else if (!rd_req[k] && !r_hold && ($urandom % 3) == 0) rd_req[k] = 1;
        rd_release[k] = (r_hold && ($urandom % 4) == 0) || ($urandom % 50) == 0;
        ovf_clr[k] = ($urandom % 10) == 0;
`ifdef VIDEO_IN_FRAME_DROP_CNT_EN
        drop_clr[k] = ($urandom % 20) == 0;
`endif
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
